// File: rtl/ili9341_spi_master.sv
// SPI mode-0 byte master for the ILI9341 panel: one byte out on mosi, one byte in on miso per start,
// with chip select framing and a registered D/CX line.
module ili9341_spi_master #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       dis_reset,
   input  logic       start,
   input  logic [7:0] data_in,
   input  logic       dc_in,
   output logic       busy,
   output logic [7:0] data_out,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_n,
   output logic       dc
);

   localparam int unsigned HW = $clog2(CLK_DIV + 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

   state_t        state, state_next;
   logic [HW-1:0] hcnt, hcnt_next;
   logic [2:0]    bit_cnt, bit_cnt_next;
   logic [7:0]    tx, tx_next;
   logic [7:0]    rx, rx_next;
   logic          busy_next, cs_n_next, sclk_next, mosi_next, dc_next;
   logic [7:0]    data_out_next;
   logic          half_done;

   assign half_done = (hcnt == HALF_LAST);

   // State register
   always_ff @(posedge clk or posedge dis_reset) begin
      if (dis_reset) state <= IDLE;
      else           state <= state_next;
   end

   // Next-state logic; a transfer is only accepted from IDLE, so start while busy is ignored
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = LEAD;
         LEAD:    if (half_done) state_next = SHIFT;
         SHIFT:   if (half_done && !sclk && bit_cnt == 3'd7) state_next = TRAIL;
         TRAIL:   if (half_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Next values for the datapath and every registered output
   always_comb begin
      hcnt_next     = hcnt;
      bit_cnt_next  = bit_cnt;
      tx_next       = tx;
      rx_next       = rx;
      busy_next     = busy;
      cs_n_next     = cs_n;
      sclk_next     = sclk;
      mosi_next     = mosi;
      dc_next       = dc;
      data_out_next = data_out;
      case (state)
         IDLE: begin
            hcnt_next    = '0;
            bit_cnt_next = '0;
            if (start) begin
               tx_next   = data_in;
               dc_next   = dc_in;
               mosi_next = data_in[7];
               busy_next = 1'b1;
               cs_n_next = 1'b0;
               sclk_next = 1'b0;
            end
         end
         LEAD: begin
            if (half_done) begin
               hcnt_next = '0;
               sclk_next = 1'b1;
            end else begin
               hcnt_next = hcnt + HW'(1);
            end
         end
         SHIFT: begin
            if (half_done) begin
               hcnt_next = '0;
               if (sclk) begin
                  // End of high phase: capture miso, advance mosi except after the last bit
                  sclk_next = 1'b0;
                  rx_next   = {rx[6:0], miso};
                  if (bit_cnt != 3'd7) begin
                     mosi_next = tx[6];
                     tx_next   = {tx[6:0], 1'b0};
                  end
               end else if (bit_cnt == 3'd7) begin
                  cs_n_next = 1'b1;
               end else begin
                  bit_cnt_next = bit_cnt + 3'd1;
                  sclk_next    = 1'b1;
               end
            end else begin
               hcnt_next = hcnt + HW'(1);
            end
         end
         TRAIL: begin
            if (half_done) begin
               hcnt_next     = '0;
               busy_next     = 1'b0;
               data_out_next = rx;
            end else begin
               hcnt_next = hcnt + HW'(1);
            end
         end
         default: begin
            hcnt_next = '0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge dis_reset) begin
      if (dis_reset) begin
         hcnt     <= '0;
         bit_cnt  <= '0;
         tx       <= '0;
         rx       <= '0;
         busy     <= 1'b0;
         cs_n     <= 1'b1;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         dc       <= 1'b0;
         data_out <= '0;
      end else begin
         hcnt     <= hcnt_next;
         bit_cnt  <= bit_cnt_next;
         tx       <= tx_next;
         rx       <= rx_next;
         busy     <= busy_next;
         cs_n     <= cs_n_next;
         sclk     <= sclk_next;
         mosi     <= mosi_next;
         dc       <= dc_next;
         data_out <= data_out_next;
      end
   end

endmodule

// File: tb/tb_ili9341_spi_master.sv
// Bench for ili9341_spi_master: a CLK_DIV=2 and a CLK_DIV=1 instance, a mode-0 slave model,
// and a bus monitor that reconstructs bytes, busy widths and sclk timing.
module tb_ili9341_spi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       dis_reset;
   logic       start2, dc_in2, busy2, sclk2, mosi2, miso2, cs_n2, dc2;
   logic [7:0] data_in2, data_out2;
   logic       start1, dc_in1, busy1, sclk1, mosi1, miso1, cs_n1, dc1;
   logic [7:0] data_in1, data_out1;

   ili9341_spi_master #(.CLK_DIV(2)) dut2 (
      .clk(clk), .dis_reset(dis_reset), .start(start2), .data_in(data_in2), .dc_in(dc_in2),
      .busy(busy2), .data_out(data_out2), .sclk(sclk2), .mosi(mosi2), .miso(miso2),
      .cs_n(cs_n2), .dc(dc2));

   ili9341_spi_master #(.CLK_DIV(1)) dut1 (
      .clk(clk), .dis_reset(dis_reset), .start(start1), .data_in(data_in1), .dc_in(dc_in1),
      .busy(busy1), .data_out(data_out1), .sclk(sclk1), .mosi(mosi1), .miso(miso1),
      .cs_n(cs_n1), .dc(dc1));

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor and slave state for the CLK_DIV=2 instance
   logic [7:0] slv2 = 8'h00;
   logic [7:0] bits2 = 8'h00;
   logic       sclk_p2 = 1'b0, busy_p2 = 1'b0, mosi_p2 = 1'b0, dc_done2 = 1'b0;
   int slv_idx2 = 0, rise_xfer2 = 0, rise_total2 = 0, blen2 = 0, last_width2 = 0;
   int done2 = 0, idle2 = 0, gap2 = 0, mosi_err2 = 0;

   always @(negedge clk) begin
      if (dis_reset) begin
         sclk_p2 <= 1'b0;
         busy_p2 <= 1'b0;
         mosi_p2 <= 1'b0;
      end else begin
         sclk_p2 <= sclk2;
         busy_p2 <= busy2;
         mosi_p2 <= mosi2;
         if (busy2) idle2 <= 0;
         else       idle2 <= idle2 + 1;
         if (busy2 && !busy_p2) begin
            gap2       <= idle2;
            blen2      <= 1;
            rise_xfer2 <= 0;
         end else if (busy2) begin
            blen2 <= blen2 + 1;
         end
         if (!busy2 && busy_p2) begin
            last_width2 <= blen2;
            done2       <= done2 + 1;
            dc_done2    <= dc2;
         end
         if (sclk2 && !sclk_p2) begin
            bits2       <= {bits2[6:0], mosi2};
            rise_xfer2  <= rise_xfer2 + 1;
            rise_total2 <= rise_total2 + 1;
         end
         if (busy2 && busy_p2 && (mosi2 !== mosi_p2) && !(sclk_p2 && !sclk2))
            mosi_err2 <= mosi_err2 + 1;
      end
      // Mode-0 slave: first bit valid while cs_n is high, next bit after each sclk fall
      if (cs_n2) begin
         slv_idx2 <= 0;
         miso2    <= slv2[7];
      end else if (sclk_p2 && !sclk2) begin
         slv_idx2 <= slv_idx2 + 1;
         miso2    <= (slv_idx2 < 7) ? slv2[3'(6 - slv_idx2)] : 1'b0;
      end
   end

   // Monitor for the CLK_DIV=1 instance
   logic busy_p1 = 1'b0, sclk_p1 = 1'b0;
   int cyc1 = 0, blen1 = 0, last_width1 = 0, done1 = 0, rise1 = 0, last_rise1 = 0;
   int period_err1 = 0, mosi0_1 = 0;

   always @(negedge clk) begin
      cyc1 <= cyc1 + 1;
      if (dis_reset) begin
         busy_p1 <= 1'b0;
         sclk_p1 <= 1'b0;
      end else begin
         busy_p1 <= busy1;
         sclk_p1 <= sclk1;
         if (busy1 && !busy_p1) begin
            blen1 <= 1;
            rise1 <= 0;
         end else if (busy1) begin
            blen1 <= blen1 + 1;
         end
         if (!busy1 && busy_p1) begin
            last_width1 <= blen1;
            done1       <= done1 + 1;
         end
         if (busy1 && !mosi1) mosi0_1 <= mosi0_1 + 1;
         if (sclk1 && !sclk_p1) begin
            if (rise1 > 0 && (cyc1 - last_rise1) != 2) period_err1 <= period_err1 + 1;
            last_rise1 <= cyc1;
            rise1      <= rise1 + 1;
         end
      end
   end

   task automatic wait_done2(input int target);
      int k = 0;
      while (done2 < target && k < 400) begin
         @(posedge clk);
         k++;
      end
      n_checks++;
      if (done2 < target) begin
         n_fail++;
         $display("FAIL wait_done2 timeout: completed=%0d required=%0d", done2, target);
      end
      @(negedge clk);
   endtask

   task automatic wait_done1(input int target);
      int k = 0;
      while (done1 < target && k < 200) begin
         @(posedge clk);
         k++;
      end
      n_checks++;
      if (done1 < target) begin
         n_fail++;
         $display("FAIL wait_done1 timeout: completed=%0d required=%0d", done1, target);
      end
      @(negedge clk);
   endtask

   // Pulse start for one edge, then scramble data_in/dc_in to prove they are not re-sampled
   task automatic start_xfer2(input logic [7:0] d, input logic dcv);
      @(negedge clk);
      start2   = 1'b1;
      data_in2 = d;
      dc_in2   = dcv;
      @(posedge clk);
      #1;
      start2   = 1'b0;
      data_in2 = 8'($urandom);
      dc_in2   = 1'($urandom);
   endtask

   task automatic test_reset();
      dis_reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (busy2 !== 1'b0)      begin n_fail++; $display("FAIL reset busy: got %b want 0", busy2); end
      n_checks++; if (cs_n2 !== 1'b1)      begin n_fail++; $display("FAIL reset cs_n: got %b want 1", cs_n2); end
      n_checks++; if (sclk2 !== 1'b0)      begin n_fail++; $display("FAIL reset sclk: got %b want 0", sclk2); end
      n_checks++; if (mosi2 !== 1'b0)      begin n_fail++; $display("FAIL reset mosi: got %b want 0", mosi2); end
      n_checks++; if (dc2 !== 1'b0)        begin n_fail++; $display("FAIL reset dc: got %b want 0", dc2); end
      n_checks++; if (data_out2 !== 8'h00) begin n_fail++; $display("FAIL reset data_out: got %h want 00", data_out2); end
      n_checks++; if (busy1 !== 1'b0 || cs_n1 !== 1'b1) begin n_fail++; $display("FAIL reset div1: busy=%b cs_n=%b want 0/1", busy1, cs_n1); end
      dis_reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_xfer2(input string name, input logic [7:0] d, input logic dcv, input logic [7:0] s);
      n_checks++; if (bits2 !== d)        begin n_fail++; $display("FAIL %s mosi byte: got %h want %h", name, bits2, d); end
      n_checks++; if (last_width2 != 36)  begin n_fail++; $display("FAIL %s busy width: got %0d want 36", name, last_width2); end
      n_checks++; if (data_out2 !== s)    begin n_fail++; $display("FAIL %s data_out: got %h want %h", name, data_out2, s); end
      n_checks++; if (dc2 !== dcv)        begin n_fail++; $display("FAIL %s dc: got %b want %b", name, dc2, dcv); end
      n_checks++; if (rise_xfer2 != 8)    begin n_fail++; $display("FAIL %s sclk rises: got %0d want 8", name, rise_xfer2); end
   endtask

   task automatic test_basic();
      int base = done2;
      int m0   = mosi_err2;
      slv2 = 8'h3C;
      start_xfer2(8'hA5, 1'b1);
      n_checks++; if (busy2 !== 1'b1 || cs_n2 !== 1'b0 || sclk2 !== 1'b0)
         begin n_fail++; $display("FAIL basic accept: busy=%b cs_n=%b sclk=%b want 1/0/0", busy2, cs_n2, sclk2); end
      n_checks++; if (mosi2 !== 1'b1 || dc2 !== 1'b1)
         begin n_fail++; $display("FAIL basic first bit: mosi=%b dc=%b want 1/1", mosi2, dc2); end
      wait_done2(base + 1);
      check_xfer2("basic", 8'hA5, 1'b1, 8'h3C);
      n_checks++; if (mosi_err2 != m0) begin n_fail++; $display("FAIL basic mosi timing: %0d off-edge changes want 0", mosi_err2 - m0); end
      n_checks++; if (busy2 !== 1'b0 || cs_n2 !== 1'b1) begin n_fail++; $display("FAIL basic end: busy=%b cs_n=%b want 0/1", busy2, cs_n2); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         logic [7:0] d = 8'($urandom);
         logic [7:0] s = 8'($urandom);
         logic       v = 1'($urandom);
         int         base = done2;
         slv2 = s;
         start_xfer2(d, v);
         wait_done2(base + 1);
         check_xfer2("random", d, v, s);
      end
   endtask

   task automatic test_ignore_start();
      logic [7:0] prev = data_out2;
      logic [7:0] s    = 8'($urandom);
      int         base = done2;
      slv2 = s;
      start_xfer2(8'h2C, 1'b0);
      repeat (9) @(negedge clk);
      start2   = 1'b1;
      data_in2 = 8'h11;
      dc_in2   = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n_checks++; if (data_out2 !== prev) begin n_fail++; $display("FAIL ignore data_out hold: got %h want %h", data_out2, prev); end
      wait_done2(base + 1);
      check_xfer2("ignore", 8'h2C, 1'b0, s);
      repeat (6) @(negedge clk);
      n_checks++; if (busy2 !== 1'b0 || done2 != base + 1)
         begin n_fail++; $display("FAIL ignore extra transfer: busy=%b completed=%0d want 0/%0d", busy2, done2, base + 1); end
   endtask

   task automatic test_back_to_back();
      int base = done2;
      int r0   = rise_total2;
      slv2 = 8'h96;
      @(negedge clk);
      start2   = 1'b1;
      data_in2 = 8'h2A;
      dc_in2   = 1'b0;
      @(posedge clk);
      #1;
      data_in2 = 8'h2B;
      dc_in2   = 1'b1;
      n_checks++; if (dc2 !== 1'b0) begin n_fail++; $display("FAIL b2b first dc: got %b want 0", dc2); end
      wait_done2(base + 1);
      start2 = 1'b0;
      n_checks++; if (bits2 !== 8'h2A || dc_done2 !== 1'b0)
         begin n_fail++; $display("FAIL b2b first: byte=%h dc=%b want 2a/0", bits2, dc_done2); end
      n_checks++; if (busy2 !== 1'b1 || dc2 !== 1'b1)
         begin n_fail++; $display("FAIL b2b second accept: busy=%b dc=%b want 1/1", busy2, dc2); end
      wait_done2(base + 2);
      check_xfer2("b2b second", 8'h2B, 1'b1, 8'h96);
      n_checks++; if (gap2 != 1) begin n_fail++; $display("FAIL b2b idle gap: got %0d want 1", gap2); end
      n_checks++; if (rise_total2 - r0 != 16) begin n_fail++; $display("FAIL b2b sclk rises: got %0d want 16", rise_total2 - r0); end
   endtask

   task automatic test_reset_abort();
      int base;
      slv2 = 8'h81;
      start_xfer2(8'h5A, 1'b1);
      repeat (9) @(posedge clk);
      #2;
      dis_reset = 1'b1;
      #1;
      n_checks++; if (busy2 !== 1'b0 || cs_n2 !== 1'b1 || sclk2 !== 1'b0)
         begin n_fail++; $display("FAIL abort outputs: busy=%b cs_n=%b sclk=%b want 0/1/0", busy2, cs_n2, sclk2); end
      n_checks++; if (data_out2 !== 8'h00 || mosi2 !== 1'b0 || dc2 !== 1'b0)
         begin n_fail++; $display("FAIL abort regs: data_out=%h mosi=%b dc=%b want 00/0/0", data_out2, mosi2, dc2); end
      slv2 = 8'h5E;
      @(negedge clk);
      @(negedge clk);
      base      = done2;
      start2    = 1'b1;
      data_in2  = 8'hC3;
      dc_in2    = 1'b0;
      dis_reset = 1'b0;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      n_checks++; if (busy2 !== 1'b1 || data_out2 !== 8'h00)
         begin n_fail++; $display("FAIL abort first start: busy=%b data_out=%h want 1/00", busy2, data_out2); end
      wait_done2(base + 1);
      check_xfer2("after abort", 8'hC3, 1'b0, 8'h5E);
   endtask

   task automatic test_clkdiv1();
      int base = done1;
      int p0   = period_err1;
      int m0   = mosi0_1;
      @(negedge clk);
      start1   = 1'b1;
      data_in1 = 8'hFF;
      dc_in1   = 1'b1;
      @(posedge clk);
      #1;
      start1   = 1'b0;
      data_in1 = 8'h00;
      n_checks++; if (busy1 !== 1'b1 || mosi1 !== 1'b1) begin n_fail++; $display("FAIL div1 accept: busy=%b mosi=%b want 1/1", busy1, mosi1); end
      wait_done1(base + 1);
      n_checks++; if (last_width1 != 18) begin n_fail++; $display("FAIL div1 busy width: got %0d want 18", last_width1); end
      n_checks++; if (data_out1 !== 8'h00) begin n_fail++; $display("FAIL div1 data_out: got %h want 00", data_out1); end
      n_checks++; if (rise1 != 8) begin n_fail++; $display("FAIL div1 sclk rises: got %0d want 8", rise1); end
      n_checks++; if (period_err1 != p0) begin n_fail++; $display("FAIL div1 sclk period: %0d periods not 2 cycles", period_err1 - p0); end
      n_checks++; if (mosi0_1 != m0 || mosi1 !== 1'b1) begin n_fail++; $display("FAIL div1 mosi: %0d low cycles, now %b, want 0 and 1", mosi0_1 - m0, mosi1); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      dis_reset = 1'b1;
      start2 = 1'b0; data_in2 = 8'h00; dc_in2 = 1'b0;
      start1 = 1'b0; data_in1 = 8'h00; dc_in1 = 1'b0; miso1 = 1'b0;
      test_reset();
      test_basic();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      test_clkdiv1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ili9341_spi_master.md
ILI9341_SPI_MASTER -- requirements
Module: ili9341_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per SCLK half-period, legal range 1..255.
REQ-002 SHALL have port clk, input, 1: system clock; all logic on its rising edge.
REQ-003 SHALL have port dis_reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: transfer request from the display controller.
REQ-005 SHALL have port data_in, input, 8: byte to transmit, sampled with start.
REQ-006 SHALL have port dc_in, input, 1: command(0)/data(1) tag, sampled with start.
REQ-007 SHALL have port busy, output, 1: transfer in progress.
REQ-008 SHALL have port data_out, output, 8: byte received on miso during the last completed transfer.
REQ-009 SHALL have port sclk, output, 1: SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-010 SHALL have port mosi, output, 1: serial data out, MSB first.
REQ-011 SHALL have port miso, input, 1: serial data in, MSB first.
REQ-012 SHALL have port cs_n, output, 1: chip select, active-low.
REQ-013 SHALL have port dc, output, 1: registered D/CX line to the panel.

Function
REQ-014 SHALL implement states IDLE, LEAD, SHIFT, TRAIL.
REQ-015 IDLE: start=1 sampled at edge T with busy=0 SHALL latch data_in and dc_in and enter LEAD; from T+1: busy=1, cs_n=0, dc=latched dc_in, mosi=data_in[7], sclk=0.
REQ-016 start while busy=1 SHALL be ignored; data_in/dc_in changes during a transfer SHALL have no effect.
REQ-017 LEAD SHALL last CLK_DIV cycles, sclk=0, then enter SHIFT.
REQ-018 SHIFT SHALL run 8 bit periods, MSB first; each = sclk=1 for CLK_DIV cycles, then sclk=0 for CLK_DIV cycles (16*CLK_DIV cycles total).
REQ-019 miso SHALL be sampled into the receive shift register on the clk edge ending each sclk-high phase.
REQ-020 mosi SHALL change only at sclk high-to-low transitions, to the next lower bit; after bit 0 it SHALL hold bit 0 until IDLE.
REQ-021 TRAIL SHALL last CLK_DIV cycles with cs_n=1, sclk=0, busy=1, then enter IDLE.
REQ-022 busy SHALL be high exactly 18*CLK_DIV consecutive cycles per transfer.
REQ-023 data_out SHALL update to the 8 received bits on the same edge busy falls and hold until the next completion.
REQ-024 dc SHALL hold its value from the last accepted start until the next accepted start.
REQ-025 start held high continuously SHALL yield back-to-back transfers separated by exactly one busy=0 cycle.
REQ-026 Half-period counter SHALL be $clog2(CLK_DIV+1) bits wide; bit counter 3 bits; no wrap glitch on sclk at CLK_DIV=1.
REQ-027 Outputs SHALL be registered; no combinational path from start, data_in or miso to any output.

Reset
REQ-028 dis_reset=1 SHALL force, asynchronously: state=IDLE, busy=0, cs_n=1, sclk=0, mosi=0, dc=0, data_out=0x00, counters=0.
REQ-029 dis_reset asserted mid-transfer SHALL abort it; data_out SHALL NOT update from the aborted transfer.
REQ-030 First start SHALL be accepted on the first rising clk edge after dis_reset deasserts.

Verification
REQ-031 CLK_DIV=2, start with data_in=0xA5, dc_in=1, slave model drives 0x3C -> mosi bits 1,0,1,0,0,1,0,1 at sclk rising edges, dc=1, busy high 36 cycles, data_out=0x3C when busy falls.
REQ-032 start pulsed with 0x11 while busy mid-transfer of 0x2C -> only 0x2C on mosi, busy width unchanged at 36, dc unchanged.
REQ-033 start held high, data_in 0x2A then 0x2B, dc_in 0 then 1 -> two transfers, exactly 1 idle cycle between them, dc toggles 0->1 at second start, 16 sclk rising edges total.
REQ-034 dis_reset pulsed at cycle 10 of a transfer -> busy=0, cs_n=1, sclk=0, data_out=0x00 immediately; next start completes a full 36-cycle transfer.
REQ-035 CLK_DIV=1, data_in=0xFF, miso tied 0 -> sclk period 2 clk cycles, busy high 18 cycles, data_out=0x00, mosi=1 throughout.
